bpb_resolve_queue: RTL and testbench

In-order queue of outstanding branch predictions, sitting between the fetch stage and the decode/resolve stage of the branch predictor.
- Fetch pushes one entry per predicted branch: PHT index plus predicted direction.
- Resolve pops the oldest entry and emits a registered update (index, actual direction) back to the pattern history table, along with a mispredict flag.
- On a mispredict, it discards all younger wrong-path entries.

---
 rtl/bpb_resolve_queue.sv | 169 ++++++++++++++++
 tb/tb_bpb_resolve_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bpb_resolve_queue.sv
// bpb_resolve_queue: in-order queue of outstanding branch predictions.
// Fetch pushes (PHT index, predicted direction). Resolve pops the oldest
// entry and, one cycle later, emits a registered PHT update with a
// mispredict flag. A mispredicting pop or an external flush empties the
// queue, discarding every younger wrong-path entry.

`ifndef BPB_T
`define BPB_T 8
`endif

module bpb_resolve_queue #(
  parameter int INDEX_WIDTH = `BPB_T,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       pred_valid_i,
  input  logic [INDEX_WIDTH-1:0]     pred_index_i,
  input  logic                       pred_taken_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  output logic                       update_en_o,
  output logic [INDEX_WIDTH-1:0]     update_index_o,
  output logic                       update_taken_o,
  output logic                       mispredict_o,
  output logic                       overflow_o,
  output logic                       spurious_o,
  output logic [CNT_WIDTH-1:0]       mispredict_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  // Saturating increment for the mispredict statistics counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  // Entry storage (not reset; contents are meaningless while unoccupied).
  logic [INDEX_WIDTH-1:0] idx_mem   [DEPTH];
  logic                   taken_mem [DEPTH];

  // Queue control state.
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [OCC_W-1:0] count_p0;

  // Per-cycle decisions.
  logic                   empty_p0;
  logic                   full_p0;
  logic                   pop_p0;
  logic                   push_p0;
  logic                   mis_p0;
  logic                   discard_p0;
  logic                   overflow_p0;
  logic                   spurious_p0;
  logic [INDEX_WIDTH-1:0] head_idx_p0;
  logic                   head_taken_p0;
  logic [OCC_W-1:0]       count_next_p0;

  // Registered outputs.
  logic                   update_en_p1;
  logic [INDEX_WIDTH-1:0] update_index_p1;
  logic                   update_taken_p1;
  logic                   mispredict_p1;
  logic                   overflow_p1;
  logic                   spurious_p1;
  logic [CNT_WIDTH-1:0]   mis_cnt_p1;

  assign empty_p0      = (count_p0 == '0);
  assign full_p0       = (count_p0 == DEPTH_C);
  assign head_idx_p0   = idx_mem[rd_ptr_p0];
  assign head_taken_p0 = taken_mem[rd_ptr_p0];

  // Decide pop/push/discard for this cycle; a discarded cycle drops the
  // wrong-path push silently (no overflow pulse for it).
  always_comb begin
    pop_p0        = en_i & resolve_valid_i & ~empty_p0;
    mis_p0        = pop_p0 & (head_taken_p0 != resolve_taken_i);
    discard_p0    = mis_p0 | (en_i & flush_i);
    push_p0       = en_i & pred_valid_i & (~full_p0 | pop_p0) & ~discard_p0;
    overflow_p0   = en_i & pred_valid_i & full_p0 & ~pop_p0 & ~discard_p0;
    spurious_p0   = en_i & resolve_valid_i & empty_p0;
    count_next_p0 = count_p0 + OCC_W'(push_p0) - OCC_W'(pop_p0);
  end

  // Write the pushed prediction at the tail; the head is read before this
  // edge so a push into a full queue alongside a pop is safe.
  always_ff @(posedge clk_i) begin
    if (push_p0) begin
      idx_mem[wr_ptr_p0]   <= pred_index_i;
      taken_mem[wr_ptr_p0] <= pred_taken_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
    end else if (discard_p0) begin
      rd_ptr_p0 <= '0;
      wr_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (pop_p0) begin
        rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
      end
      if (push_p0) begin
        wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(1);
      end
      count_p0 <= count_next_p0;
    end
  end

  // ---- stage boundary: resolve decision -> registered PHT update ----
  // Update strobes and status pulses; index/direction hold when no pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      update_en_p1    <= 1'b0;
      update_index_p1 <= '0;
      update_taken_p1 <= 1'b0;
      mispredict_p1   <= 1'b0;
      overflow_p1     <= 1'b0;
      spurious_p1     <= 1'b0;
    end else begin
      update_en_p1  <= pop_p0;
      mispredict_p1 <= mis_p0;
      overflow_p1   <= overflow_p0;
      spurious_p1   <= spurious_p0;
      if (pop_p0) begin
        update_index_p1 <= head_idx_p0;
        update_taken_p1 <= resolve_taken_i;
      end
    end
  end

  // Saturating mispredict counter, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mis_cnt_p1 <= '0;
    end else if (mis_p0) begin
      mis_cnt_p1 <= sat_inc(mis_cnt_p1);
    end
  end

  assign full_o           = full_p0;
  assign empty_o          = empty_p0;
  assign count_o          = count_p0;
  assign update_en_o      = update_en_p1;
  assign update_index_o   = update_index_p1;
  assign update_taken_o   = update_taken_p1;
  assign mispredict_o     = mispredict_p1;
  assign overflow_o       = overflow_p1;
  assign spurious_o       = spurious_p1;
  assign mispredict_cnt_o = mis_cnt_p1;

endmodule

// File: tb/tb_bpb_resolve_queue.sv
// Self-checking bench for bpb_resolve_queue: directed steps followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_bpb_resolve_queue;

  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          pred_valid_i = 1'b0;
  logic [IW-1:0] pred_index_i = '0;
  logic          pred_taken_i = 1'b0;
  logic          resolve_valid_i = 1'b0;
  logic          resolve_taken_i = 1'b0;
  logic          full_o, empty_o;
  logic [2:0]    count_o;
  logic          update_en_o, update_taken_o, mispredict_o;
  logic [IW-1:0] update_index_o;
  logic          overflow_o, spurious_o;
  logic [CW-1:0] mispredict_cnt_o;

  bpb_resolve_queue #(.INDEX_WIDTH(IW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .pred_valid_i(pred_valid_i), .pred_index_i(pred_index_i), .pred_taken_i(pred_taken_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .update_en_o(update_en_o), .update_index_o(update_index_o),
    .update_taken_o(update_taken_o), .mispredict_o(mispredict_o),
    .overflow_o(overflow_o), .spurious_o(spurious_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int ncmp = 0;

  // Reference model: a plain queue of {index, taken} plus expected outputs.
  logic [IW:0] mq[$];
  logic          e_upd, e_tk, e_mis, e_ovf, e_spur;
  logic [IW-1:0] e_idx;
  int            e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_upd = 0; e_tk = 0; e_mis = 0; e_ovf = 0; e_spur = 0; e_idx = '0; e_cnt = 0;
  endtask

  task automatic check_all();
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("update_en", 32'(update_en_o), 32'(e_upd));
    chk("update_index", 32'(update_index_o), 32'(e_idx));
    chk("update_taken", 32'(update_taken_o), 32'(e_tk));
    chk("mispredict", 32'(mispredict_o), 32'(e_mis));
    chk("overflow", 32'(overflow_o), 32'(e_ovf));
    chk("spurious", 32'(spurious_o), 32'(e_spur));
    chk("mis_cnt", 32'(mispredict_cnt_o), 32'(e_cnt));
  endtask

  // One clock of stimulus: drive at posedge+1, predict, sample at posedge+1.
  task automatic step(input logic en, input logic pv, input logic [IW-1:0] idx,
                      input logic pt, input logic rv, input logic rt, input logic fl);
    logic pop, mis, disc, fullb, psh;
    logic [IW:0] head;
    en_i = en; pred_valid_i = pv; pred_index_i = idx; pred_taken_i = pt;
    resolve_valid_i = rv; resolve_taken_i = rt; flush_i = fl;
    fullb = (mq.size() == DEPTH);
    pop   = en && rv && (mq.size() > 0);
    head  = pop ? mq[0] : '0;
    mis   = pop && (head[0] != rt);
    disc  = mis || (en && fl);
    psh   = en && pv && !disc && (!fullb || pop);
    e_ovf  = en && pv && fullb && !pop && !disc;
    e_spur = en && rv && (mq.size() == 0);
    e_upd  = pop;
    e_mis  = mis;
    if (pop) begin
      e_idx = head[IW:1];
      e_tk  = rt;
      void'(mq.pop_front());
    end
    if (mis && e_cnt < CMAX) e_cnt++;
    if (disc) mq.delete();
    else if (psh) mq.push_back({idx, pt});
    @(posedge clk_i); #1;
    vectors++;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic t);
    step(1'b1, 1'b1, idx, t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic t);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, t, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    vectors++;
    check_all();

    // In-order push then resolve with correct predictions.
    push(8'd3, 1'b1); push(8'd5, 1'b0); push(8'd7, 1'b1);
    chk("cnt_after_3_push", 32'(count_o), 32'd3);
    resolve(1'b1);
    chk("upd0_idx", 32'(update_index_o), 32'd3);
    resolve(1'b0);
    chk("upd1_idx", 32'(update_index_o), 32'd5);
    resolve(1'b1);
    chk("upd2_idx", 32'(update_index_o), 32'd7);
    chk("upd2_mis", 32'(mispredict_o), 32'd0);
    idle();

    // Fill, overflow, then push+pop on a full queue across pointer wrap.
    for (int i = 0; i < DEPTH; i++) push(8'(20 + i), 1'(i));
    push(8'd99, 1'b1);
    chk("ovf_pulse", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'(40 + i), 1'(i), 1'b1, mq[0][0], 1'b0);
      chk("full_stays", 32'(count_o), 32'd4);
    end
    while (mq.size() > 0) resolve(mq[0][0]);
    idle();

    // Mispredict with a concurrent push.
    push(8'd9, 1'b1); push(8'd2, 1'b1); push(8'd6, 1'b0);
    step(1'b1, 1'b1, 8'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mis_idx", 32'(update_index_o), 32'd9);
    chk("mis_flag", 32'(mispredict_o), 32'd1);
    chk("mis_count0", 32'(count_o), 32'd0);
    chk("mis_cnt1", 32'(mispredict_cnt_o), 32'd1);

    // Spurious resolve, then flush with a concurrent resolve.
    resolve(1'b1);
    chk("spurious_pulse", 32'(spurious_o), 32'd1);
    idle();
    push(8'd12, 1'b0); push(8'd13, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_upd", 32'(update_en_o), 32'd1);
    idle();
    chk("flush_one_upd", 32'(update_en_o), 32'd0);
    push(8'd14, 1'b1);
    step(1'b1, 1'b1, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pipeline hold.
    push(8'd30, 1'b1); push(8'd31, 1'b0);
    repeat (3) step(1'b0, 1'b1, 8'd77, 1'b1, 1'b1, 1'b0, 1'b1);
    resolve(1'b1); resolve(1'b0);

    // Asynchronous reset mid-burst.
    push(8'd50, 1'b1); push(8'd51, 1'b1); resolve(1'b1);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    vectors++;
    check_all();
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic en, pv, rv, rt, fl;
      en = ($urandom_range(0, 9) != 0);
      pv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 1) != 0);
      fl = ($urandom_range(0, 29) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) < 7) rt = mq[0][0];
      else rt = 1'($urandom);
      step(en, pv, 8'($urandom), 1'($urandom), rv, rt, fl);
    end
    chk("cnt_saturated", 32'(mispredict_cnt_o), 32'(CMAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
